ser_rx_deser: RTL and testbench

Framed serial receiver. It is the receive end of the serial stream that the universal shift register drives from its serial output.
Detects a start bit, shifts in n data bits MSB first, checks the stop bit (and optionally parity), and presents the parallel word on a valid/ready handshake.
It sits between a serial line and a parallel consumer, and reports framing, parity and overrun errors.

---
 rtl/ser_pkg.sv | 17 +
 rtl/rx_sipo.sv | 39 +++
 rtl/ser_rx_deser.sv | 136 +++++++++++++
 tb/tb_ser_rx_deser.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ser_pkg.sv
// Shared definitions for the framed serial receiver.
//   state_t   : receiver FSM states
//   START_LVL : line level that marks a start bit
//   STOP_LVL  : line level that a good stop bit must have
package ser_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam logic START_LVL = 1'b1;
    localparam logic STOP_LVL  = 1'b0;

endpackage

// File: rtl/rx_sipo.sv
// MSB-first serial-in/parallel-out shift register with bit counter.
//   clk  : system clock
//   rst  : synchronous active-high reset (clears word and counter)
//   clr  : synchronous clear at the start of a frame
//   en   : shift din in and advance the counter
//   din  : serial data bit
//   word : assembled parallel word, first received bit in the MSB
//   done : the shift taking place while en=1 delivers the n-th bit
module rx_sipo #(
    parameter int unsigned n = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic         din,
    output logic [n-1:0] word,
    output logic         done
);

    localparam int unsigned cnt_w = $clog2(n) + 1;

    logic [cnt_w-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            word  <= '0;
            cnt_q <= '0;
        end else if (en) begin
            word  <= {word[n-2:0], din};
            cnt_q <= cnt_q + cnt_w'(1);
        end
    end

    // Counter holds the number of bits already taken, so n-1 means the
    // current shift is the last data bit of the frame.
    assign done = (cnt_q == cnt_w'(n - 1));

endmodule

// File: rtl/ser_rx_deser.sv
// Framed serial receiver: start bit (1), n data bits MSB first, optional
// even-parity bit, stop bit (0). The received word is offered on a
// valid/ready handshake; framing, parity and overrun errors are reported
// as one-cycle pulses.
// Optional feature: define SER_RX_PARITY_EN to add the parity bit and check.
//   clk        : system clock
//   rst        : synchronous active-high reset
//   bit_en     : bit-sample strobe; the line is sampled only when high
//   in         : serial line, idles low
//   ready      : consumer accepts q while valid is high
//   q          : received word
//   valid      : q holds an unconsumed word
//   busy       : a frame is in progress
//   frame_err  : pulse, stop bit was not 0
//   parity_err : pulse, parity mismatch (tied low without parity)
//   overrun    : pulse, good frame dropped because q was still unconsumed
module ser_rx_deser
    import ser_pkg::*;
#(
    parameter int unsigned n = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         bit_en,
    input  logic         in,
    input  logic         ready,
    output logic [n-1:0] q,
    output logic         valid,
    output logic         busy,
    output logic         frame_err,
    output logic         parity_err,
    output logic         overrun
);

    state_t       state_q;
    logic [n-1:0] word;
    logic         done;
    logic         sipo_clr;
    logic         sipo_en;

    assign sipo_clr = (state_q == IDLE) && bit_en && (in == START_LVL);
    assign sipo_en  = (state_q == DATA) && bit_en;
    assign busy     = (state_q != IDLE);

    rx_sipo #(
        .n(n)
    ) u_sipo (
        .clk  (clk),
        .rst  (rst),
        .clr  (sipo_clr),
        .en   (sipo_en),
        .din  (in),
        .word (word),
        .done (done)
    );

`ifdef SER_RX_PARITY_EN
    logic par_q;
    logic par_bad;

    // Even parity: data bits plus parity bit must XOR to zero.
    assign par_bad = ^{word, par_q};
`else
    assign parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            q          <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef SER_RX_PARITY_EN
            par_q      <= 1'b0;
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
`ifdef SER_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            // Handshake runs regardless of bit_en; a load below overrides it.
            if (valid && ready) begin
                valid <= 1'b0;
            end

            if (bit_en) begin
                case (state_q)
                    IDLE: begin
                        if (in == START_LVL) begin
                            state_q <= DATA;
                        end
                    end
                    DATA: begin
                        if (done) begin
`ifdef SER_RX_PARITY_EN
                            state_q <= PARITY;
`else
                            state_q <= STOP;
`endif
                        end
                    end
`ifdef SER_RX_PARITY_EN
                    PARITY: begin
                        par_q   <= in;
                        state_q <= STOP;
                    end
`endif
                    STOP: begin
                        state_q <= IDLE;
                        // Parity failure outranks the stop-bit check.
`ifdef SER_RX_PARITY_EN
                        if (par_bad) begin
                            parity_err <= 1'b1;
                        end else
`endif
                        if (in != STOP_LVL) begin
                            frame_err <= 1'b1;
                        end else if (!valid || ready) begin
                            q     <= word;
                            valid <= 1'b1;
                        end else begin
                            overrun <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ser_rx_deser.sv
// Scoreboard bench for ser_rx_deser (n=4). Stimulus pushes expected events;
// a monitor pops them as the DUT presents words or error pulses.
module tb_ser_rx_deser;

    localparam logic [1:0] K_WORD = 2'd0;
    localparam logic [1:0] K_FERR = 2'd1;
    localparam logic [1:0] K_PERR = 2'd2;
    localparam logic [1:0] K_OVR  = 2'd3;

    logic       clk;
    logic       rst;
    logic       bit_en;
    logic       in;
    logic       ready;
    logic [3:0] q;
    logic       valid;
    logic       busy;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;

    int n_vec;
    int n_miss;

    logic [5:0] exp_q[$];

    ser_rx_deser #(
        .n(4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_en     (bit_en),
        .in         (in),
        .ready      (ready),
        .q          (q),
        .valid      (valid),
        .busy       (busy),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push(input logic [1:0] kind, input logic [3:0] data);
        exp_q.push_back({kind, data});
    endtask

    // Monitor side of the scoreboard.
    task automatic observe(input logic [1:0] kind, input logic [3:0] data);
        logic [5:0] e;
        n_vec++;
        if (exp_q.size() == 0) begin
            n_miss++;
            $display("FAIL unexpected_event: got kind %0d data %0h, required none", kind, data);
        end else begin
            e = exp_q.pop_front();
            if (e !== {kind, data}) begin
                n_miss++;
                $display("FAIL event: got kind %0d data %0h, required kind %0d data %0h",
                         kind, data, e[5:4], e[3:0]);
            end
        end
    endtask

    initial begin
        logic pv;
        logic pr;
        pv = 1'b0;
        pr = 1'b0;
        forever begin
            @(negedge clk);
            // A new word is present when valid is high and the previous edge
            // did not hold an unconsumed word.
            if (valid === 1'b1 && (pv !== 1'b1 || pr === 1'b1)) observe(K_WORD, q);
            if (frame_err === 1'b1) observe(K_FERR, 4'h0);
            if (parity_err === 1'b1) observe(K_PERR, 4'h0);
            if (overrun === 1'b1) observe(K_OVR, 4'h0);
            pv = valid;
            pr = ready;
        end
    end

    // One sampled bit; with alt, a bit_en=0 cycle follows carrying the
    // inverted level, during which busy must match hold_busy.
    task automatic send_bit(input logic b, input logic alt, input logic hold_busy);
        bit_en = 1'b1;
        in     = b;
        @(posedge clk);
        #1;
        if (alt) begin
            bit_en = 1'b0;
            in     = ~b;
            @(posedge clk);
            #1;
            chk("hold_busy", {31'd0, busy}, {31'd0, hold_busy});
        end
    endtask

    task automatic send_frame(input logic [3:0] d, input logic stop_b, input logic par_flip,
                              input logic rdy_stop, input logic alt);
        ready = 1'b0;
        send_bit(1'b1, alt, 1'b1);
        for (int i = 3; i >= 0; i--) send_bit(d[i], alt, 1'b1);
`ifdef SER_RX_PARITY_EN
        send_bit((^d) ^ par_flip, alt, 1'b1);
`endif
        ready = rdy_stop;
        send_bit(stop_b, alt, 1'b0);
        ready  = 1'b0;
        in     = 1'b0;
        bit_en = 1'b1;
    endtask

    task automatic consume();
        ready = 1'b1;
        @(posedge clk);
        #1;
        ready = 1'b0;
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst    = 1'b1;
        bit_en = 1'b1;
        in     = 1'b0;
        ready  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_q", {28'd0, q}, 32'h0);
        chk("rst_valid", {31'd0, valid}, 32'h0);
        chk("rst_busy", {31'd0, busy}, 32'h0);
        chk("rst_errs", {29'd0, frame_err, parity_err, overrun}, 32'h0);

        // 1: basic frame 1001, then consume.
        push(K_WORD, 4'b1001);
        send_frame(4'b1001, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t1_valid", {31'd0, valid}, 32'h1);
        chk("t1_q", {28'd0, q}, 32'h9);
        chk("t1_busy", {31'd0, busy}, 32'h0);
        consume();
        chk("t1_cleared", {31'd0, valid}, 32'h0);

        // 2: bad stop bit; the trailing 1 must not start a new frame.
        push(K_FERR, 4'h0);
        send_frame(4'b1101, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t2_valid", {31'd0, valid}, 32'h0);
        chk("t2_q", {28'd0, q}, 32'h9);
        chk("t2_busy", {31'd0, busy}, 32'h0);

        // 3: overrun, then reload with ready on the stop edge.
        push(K_WORD, 4'b1001);
        send_frame(4'b1001, 1'b0, 1'b0, 1'b0, 1'b0);
        push(K_OVR, 4'h0);
        send_frame(4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t3_q_kept", {28'd0, q}, 32'h9);
        chk("t3_valid", {31'd0, valid}, 32'h1);
        push(K_WORD, 4'b0110);
        send_frame(4'b0110, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("t3_q_new", {28'd0, q}, 32'h6);
        chk("t3_valid_new", {31'd0, valid}, 32'h1);
        consume();
        chk("t3_cleared", {31'd0, valid}, 32'h0);

        // 4: bit_en alternating.
        push(K_WORD, 4'b1001);
        send_frame(4'b1001, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t4_q", {28'd0, q}, 32'h9);
        chk("t4_valid", {31'd0, valid}, 32'h1);
        consume();

        // 5: reset mid-frame after two data bits.
        send_bit(1'b1, 1'b0, 1'b1);
        send_bit(1'b1, 1'b0, 1'b1);
        send_bit(1'b0, 1'b0, 1'b1);
        chk("t5_busy_pre", {31'd0, busy}, 32'h1);
        rst = 1'b1;
        in  = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        in  = 1'b0;
        chk("t5_busy", {31'd0, busy}, 32'h0);
        chk("t5_valid", {31'd0, valid}, 32'h0);
        chk("t5_q", {28'd0, q}, 32'h0);
        push(K_WORD, 4'b0110);
        send_frame(4'b0110, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t5_q_after", {28'd0, q}, 32'h6);
        consume();

`ifdef SER_RX_PARITY_EN
        // 6: parity good, parity bad, parity bad with bad stop.
        push(K_WORD, 4'b1011);
        send_frame(4'b1011, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t6_q", {28'd0, q}, 32'hb);
        consume();
        push(K_PERR, 4'h0);
        send_frame(4'b1011, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("t6_valid", {31'd0, valid}, 32'h0);
        push(K_PERR, 4'h0);
        send_frame(4'b1011, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("t6_q_kept", {28'd0, q}, 32'hb);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("pending_events", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
